// File: rtl/line_router.sv
// line_router: routes synchronised input lines (or constant 0/1) to each output
// with per-output inversion and a conditioning mode (direct, debounce, rising
// pulse, toggle). Configuration goes to shadow entries first and is committed
// to the active set atomically.
//
// Ports:
//   clk, rst       - rising-edge clock, synchronous active-high reset
//   input_lines    - asynchronous raw lines, synchronised internally
//   output_lines   - registered routed lines
//   cfg_valid      - shadow write strobe for entry cfg_output
//   cfg_output     - output index being written
//   cfg_source     - input index, NUM_INPUTS = const 0, NUM_INPUTS+1 = const 1
//   cfg_mode       - 0 direct, 1 debounce, 2 rise pulse, 3 toggle
//   cfg_invert     - invert selected line before mode processing
//   cfg_commit     - copy every shadow entry to active
//   cfg_err        - one-cycle pulse after a rejected write
//   cfg_pending    - shadow holds uncommitted writes
module line_router #(
  parameter int unsigned NUM_INPUTS  = 8,
  parameter int unsigned NUM_OUTPUTS = 10,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 8,
  localparam int unsigned SEL_W = $clog2(NUM_INPUTS + 2),
  localparam int unsigned OUT_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  input_lines,
  output logic [NUM_OUTPUTS-1:0] output_lines,
  input  logic                   cfg_valid,
  input  logic [OUT_W-1:0]       cfg_output,
  input  logic [SEL_W-1:0]       cfg_source,
  input  logic [1:0]             cfg_mode,
  input  logic                   cfg_invert,
  input  logic                   cfg_commit,
  output logic                   cfg_err,
  output logic                   cfg_pending
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN);

  // Synchroniser chain, stage 0 captures the raw lines
  logic [SYNC_STAGES-1:0][NUM_INPUTS-1:0] sync_q;
  logic [NUM_INPUTS-1:0]                  sync_last;

  // Shadow and active configuration
  logic [NUM_OUTPUTS-1:0][SEL_W-1:0] src_sh_q, src_act_q;
  logic [NUM_OUTPUTS-1:0][1:0]       mode_sh_q, mode_act_q;
  logic [NUM_OUTPUTS-1:0]            inv_sh_q, inv_act_q;

  // Per-output conditioning state
  logic [NUM_OUTPUTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_OUTPUTS-1:0]            filt_q, filt_d;
  logic [NUM_OUTPUTS-1:0]            prev_q, prev_d;
  logic [NUM_OUTPUTS-1:0]            tog_q, tog_d;
  logic [NUM_OUTPUTS-1:0]            out_q, out_d;
  logic [NUM_OUTPUTS-1:0]            s_cur, s_new, rise;

  logic err_q, pend_q;
  logic wr_in_range, wr_ok;

  assign sync_last    = sync_q[SYNC_STAGES-1];
  assign output_lines = out_q;
  assign cfg_err      = err_q;
  assign cfg_pending  = pend_q;

  // Range check widened by one bit so a power-of-two NUM_OUTPUTS cannot alias to 0
  assign wr_in_range = ({1'b0, cfg_output} < (OUT_W + 1)'(NUM_OUTPUTS)) &&
                       (cfg_source <= SEL_W'(NUM_INPUTS + 1));
  assign wr_ok       = cfg_valid && wr_in_range;

  // Selected line: synchronised input or constant, then optional inversion
  function automatic logic pick_line(input logic [SEL_W-1:0]      src,
                                     input logic                  inv,
                                     input logic [NUM_INPUTS-1:0] lines);
    logic v;
    v = (src == SEL_W'(NUM_INPUTS + 1));
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      if (src == SEL_W'(i)) v = lines[i];
    end
    return v ^ inv;
  endfunction

  // Per-output conditioning next state; commit reseeds state from the new map
  always_comb begin
    s_cur  = '0;
    s_new  = '0;
    rise   = '0;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    prev_d = prev_q;
    tog_d  = tog_q;
    out_d  = out_q;
    for (int o = 0; o < int'(NUM_OUTPUTS); o++) begin
      s_cur[o]  = pick_line(src_act_q[o], inv_act_q[o], sync_last);
      s_new[o]  = pick_line(src_sh_q[o], inv_sh_q[o], sync_last);
      rise[o]   = s_cur[o] & ~prev_q[o];
      prev_d[o] = s_cur[o];
      tog_d[o]  = tog_q[o] ^ rise[o];

      // Debounce: change accepted only after FILTER_LEN consecutive differing cycles
      if (s_cur[o] == filt_q[o]) begin
        cnt_d[o] = '0;
      end else if (cnt_q[o] == CNT_W'(FILTER_LEN - 1)) begin
        filt_d[o] = s_cur[o];
        cnt_d[o]  = '0;
      end else begin
        cnt_d[o] = cnt_q[o] + CNT_W'(1);
      end

      case (mode_act_q[o])
        2'd0:    out_d[o] = s_cur[o];
        2'd1:    out_d[o] = filt_q[o];
        2'd2:    out_d[o] = rise[o];
        default: out_d[o] = tog_d[o];
      endcase

      if (cfg_commit) begin
        cnt_d[o]  = '0;
        filt_d[o] = s_new[o];
        prev_d[o] = s_new[o];
        tog_d[o]  = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      src_sh_q   <= {NUM_OUTPUTS{SEL_W'(NUM_INPUTS)}};
      src_act_q  <= {NUM_OUTPUTS{SEL_W'(NUM_INPUTS)}};
      mode_sh_q  <= '0;
      mode_act_q <= '0;
      inv_sh_q   <= '0;
      inv_act_q  <= '0;
      cnt_q      <= '0;
      filt_q     <= '0;
      prev_q     <= '0;
      tog_q      <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      sync_q[0] <= input_lines;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end

      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
      tog_q  <= tog_d;
      out_q  <= out_d;

      // Active takes the shadow as it stood before this edge
      if (cfg_commit) begin
        src_act_q  <= src_sh_q;
        mode_act_q <= mode_sh_q;
        inv_act_q  <= inv_sh_q;
      end

      for (int o = 0; o < int'(NUM_OUTPUTS); o++) begin
        if (wr_ok && (cfg_output == OUT_W'(o))) begin
          src_sh_q[o]  <= cfg_source;
          mode_sh_q[o] <= cfg_mode;
          inv_sh_q[o]  <= cfg_invert;
        end
      end

      err_q <= cfg_valid & ~wr_in_range;

      // A write in the commit cycle keeps the shadow ahead of active
      if (wr_ok) begin
        pend_q <= 1'b1;
      end else if (cfg_commit) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule
